// File: rtl/fetch_exc_pkg.sv
// Shared definitions for the fetch-stage exception unit.
//   - RISC-V instruction exception cause codes used by the fetch stage
//   - fetch_exc_state_e : state of the pending-exception FSM
package fetch_exc_pkg;

  localparam int EXC_INSTR_MISALIGN     = 0;
  localparam int EXC_INSTR_ACCESS_FAULT = 1;
  localparam int EXC_INST_PAGE_FAULT    = 12;
  localparam int EXC_NONE               = 14;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PEND       = 2'd1,
    WAIT_REDIR = 2'd2
  } fetch_exc_state_e;

endpackage

// File: rtl/m_fetch_exc_prio.sv
// Combinational cause priority encoder for fetch exceptions.
// Priority, highest first: page fault > access fault > misaligned PC.
// Ports:
//   misalign     in   1           PC is not aligned to IALIGN
//   access_fault in   1           instruction access fault
//   page_fault   in   1           instruction page fault
//   valid        out  1           at least one cause is present
//   code         out  EXC_CODE_W  winning cause code, EXC_NONE if none
module m_fetch_exc_prio
  import fetch_exc_pkg::*;
#(
  parameter int EXC_CODE_W = 4
) (
  input  logic                  misalign,
  input  logic                  access_fault,
  input  logic                  page_fault,
  output logic                  valid,
  output logic [EXC_CODE_W-1:0] code
);

  always_comb begin
    valid = misalign | access_fault | page_fault;
    code  = EXC_CODE_W'(EXC_NONE);
    if (page_fault) begin
      code = EXC_CODE_W'(EXC_INST_PAGE_FAULT);
    end else if (access_fault) begin
      code = EXC_CODE_W'(EXC_INSTR_ACCESS_FAULT);
    end else if (misalign) begin
      code = EXC_CODE_W'(EXC_INSTR_MISALIGN);
    end
  end

endmodule

// File: rtl/m_fetch_exc_unit.sv
// Fetch-stage exception generator between the MMU/IF stage and the CSR trap
// logic. Detects misaligned PC, instruction page fault and (when the macro
// FETCH_ACCESS_FAULT_EN is defined) instruction access fault, holds one
// pending exception across IF stalls until acked, then stays quiet until the
// trap redirect flushes the pipe. Counts raised exceptions (saturating).
//
// Handshake: exc_req_o is held high with code/tval frozen while an exception
// is pending; it is consumed only in a cycle where exc_ack_i=1 and
// if_stall=0. An ack during a stall is dropped and must be re-issued. Any
// flush (csr/exe redirect or WFI) drops a pending exception without an ack.
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   pc              fetch PC
//   fetch_valid     pc/fault inputs valid this cycle
//   csr_new_pc_req, exe_new_pc_req, wfi_req   flush sources
//   if_stall        IF stalled; pending exception holds
//   i_page_fault    MMU page fault for pc
//   i_access_fault  access fault (ignored unless FETCH_ACCESS_FAULT_EN)
//   exc_ack_i       downstream consumed the exception
//   exc_req_o       exception pending
//   exc_code_o      cause code, EXC_NONE when nothing pending
//   exc_tval_o      faulting PC, 0 when nothing pending
//   exc_cnt_o       saturating count of raised exceptions
//   fsm_state       current FSM state (debug)
module m_fetch_exc_unit
  import fetch_exc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IALIGN     = 32,
  parameter int EXC_CODE_W = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pc,
  input  logic                  fetch_valid,
  input  logic                  csr_new_pc_req,
  input  logic                  exe_new_pc_req,
  input  logic                  wfi_req,
  input  logic                  if_stall,
  input  logic                  i_page_fault,
  input  logic                  i_access_fault,
  input  logic                  exc_ack_i,
  output logic                  exc_req_o,
  output logic [EXC_CODE_W-1:0] exc_code_o,
  output logic [XLEN-1:0]       exc_tval_o,
  output logic [CNT_W-1:0]      exc_cnt_o,
  output fetch_exc_state_e      fsm_state
);

  fetch_exc_state_e      state_q, state_d;
  logic [EXC_CODE_W-1:0] code_q, code_d;
  logic [XLEN-1:0]       tval_q, tval_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  flush;
  logic                  misalign;
  logic                  access_fault;
  logic                  cause_valid;
  logic [EXC_CODE_W-1:0] cause_code;

  assign flush    = csr_new_pc_req | exe_new_pc_req | wfi_req;
  // With compressed instructions only bit 0 must be clear.
  assign misalign = (IALIGN == 16) ? pc[0] : (pc[1] | pc[0]);

`ifdef FETCH_ACCESS_FAULT_EN
  assign access_fault = i_access_fault;
`else
  logic unused_access_fault;
  assign unused_access_fault = i_access_fault;
  assign access_fault        = 1'b0;
`endif

  m_fetch_exc_prio #(
    .EXC_CODE_W(EXC_CODE_W)
  ) u_prio (
    .misalign    (misalign),
    .access_fault(access_fault),
    .page_fault  (i_page_fault),
    .valid       (cause_valid),
    .code        (cause_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= EXC_CODE_W'(EXC_NONE);
      tval_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tval_q  <= tval_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tval_d  = tval_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A flush in the same cycle wins over a fault: that PC is discarded.
        if (!flush && fetch_valid && cause_valid) begin
          state_d = PEND;
          code_d  = cause_code;
          tval_d  = pc;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PEND: begin
        if (flush || (exc_ack_i && !if_stall)) begin
          state_d = flush ? IDLE : WAIT_REDIR;
          code_d  = EXC_CODE_W'(EXC_NONE);
          tval_d  = '0;
        end
      end
      WAIT_REDIR: begin
        if (flush) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        code_d  = EXC_CODE_W'(EXC_NONE);
        tval_d  = '0;
      end
    endcase
  end

  assign exc_req_o  = (state_q == PEND);
  assign exc_code_o = code_q;
  assign exc_tval_o = tval_q;
  assign exc_cnt_o  = cnt_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_m_fetch_exc_unit.sv
module tb_m_fetch_exc_unit;
  import fetch_exc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc;
  logic fetch_valid, csr_new_pc_req, exe_new_pc_req, wfi_req, if_stall;
  logic i_page_fault, i_access_fault, exc_ack_i;

  // Three instances share the stimulus:
  //   0: IALIGN=32, CNT_W=8   1: IALIGN=16, CNT_W=8   2: IALIGN=32, CNT_W=2
  logic             req [3];
  logic [3:0]       code[3];
  logic [31:0]      tval[3];
  logic [7:0]       cnt [3];
  fetch_exc_state_e st  [3];
  logic [7:0]       cnt0, cnt1;
  logic [1:0]       cnt2;
  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;
  assign cnt[2] = {6'd0, cnt2};

  m_fetch_exc_unit #(.XLEN(32), .IALIGN(32), .EXC_CODE_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fetch_valid),
    .csr_new_pc_req(csr_new_pc_req), .exe_new_pc_req(exe_new_pc_req),
    .wfi_req(wfi_req), .if_stall(if_stall), .i_page_fault(i_page_fault),
    .i_access_fault(i_access_fault), .exc_ack_i(exc_ack_i),
    .exc_req_o(req[0]), .exc_code_o(code[0]), .exc_tval_o(tval[0]),
    .exc_cnt_o(cnt0), .fsm_state(st[0]));

  m_fetch_exc_unit #(.XLEN(32), .IALIGN(16), .EXC_CODE_W(4), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fetch_valid),
    .csr_new_pc_req(csr_new_pc_req), .exe_new_pc_req(exe_new_pc_req),
    .wfi_req(wfi_req), .if_stall(if_stall), .i_page_fault(i_page_fault),
    .i_access_fault(i_access_fault), .exc_ack_i(exc_ack_i),
    .exc_req_o(req[1]), .exc_code_o(code[1]), .exc_tval_o(tval[1]),
    .exc_cnt_o(cnt1), .fsm_state(st[1]));

  m_fetch_exc_unit #(.XLEN(32), .IALIGN(32), .EXC_CODE_W(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fetch_valid),
    .csr_new_pc_req(csr_new_pc_req), .exe_new_pc_req(exe_new_pc_req),
    .wfi_req(wfi_req), .if_stall(if_stall), .i_page_fault(i_page_fault),
    .i_access_fault(i_access_fault), .exc_ack_i(exc_ack_i),
    .exc_req_o(req[2]), .exc_code_o(code[2]), .exc_tval_o(tval[2]),
    .exc_cnt_o(cnt2), .fsm_state(st[2]));

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract view: an exception is either pending, already acked and waiting
  // for the redirect, or neither.
  int          ialign [3] = '{32, 16, 32};
  int          cnt_max[3] = '{255, 255, 3};
  bit          m_pend [3] = '{0, 0, 0};
  bit          m_wait [3] = '{0, 0, 0};
  int          m_code [3] = '{14, 14, 14};
  logic [31:0] m_tval [3] = '{0, 0, 0};
  int          m_cnt  [3] = '{0, 0, 0};

  function automatic int cause_of(input int i, input logic [31:0] p,
                                  input bit pf, input bit af);
    bit af_en;
`ifdef FETCH_ACCESS_FAULT_EN
    af_en = 1;
`else
    af_en = 0;
`endif
    if (pf) return 12;
    if (af && af_en) return 1;
    if ((p % (ialign[i] / 8)) != 0) return 0;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 0; m_wait[i] = 0; m_code[i] = 14; m_tval[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int c;
        c = cause_of(i, pc, i_page_fault, i_access_fault);
        if (csr_new_pc_req || exe_new_pc_req || wfi_req) begin
          m_pend[i] = 0; m_wait[i] = 0;
        end else if (m_pend[i]) begin
          if (exc_ack_i && !if_stall) begin
            m_pend[i] = 0; m_wait[i] = 1;
          end
        end else if (!m_wait[i] && fetch_valid && c >= 0) begin
          m_pend[i] = 1;
          m_code[i] = c;
          m_tval[i] = pc;
          if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        end
      end
    end
  end

  // One compare process: every falling edge, all outputs of all instances.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      fetch_exc_state_e exp_st;
      exp_st = m_pend[i] ? PEND : (m_wait[i] ? WAIT_REDIR : IDLE);
      check($sformatf("req[%0d]", i),   {31'd0, req[i]}, {31'd0, m_pend[i]});
      check($sformatf("code[%0d]", i),  {28'd0, code[i]}, m_pend[i] ? m_code[i] : 14);
      check($sformatf("tval[%0d]", i),  tval[i], m_pend[i] ? m_tval[i] : 32'd0);
      check($sformatf("cnt[%0d]", i),   {24'd0, cnt[i]}, m_cnt[i]);
      check($sformatf("state[%0d]", i), {30'd0, st[i]}, {30'd0, exp_st});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    fetch_valid = 0; csr_new_pc_req = 0; exe_new_pc_req = 0; wfi_req = 0;
    if_stall = 0; i_page_fault = 0; i_access_fault = 0; exc_ack_i = 0;
  endtask

  // Pulse one flush source for a cycle with all fetch inputs quiet.
  task automatic flush_cycle(input int src);
    clear_in();
    case (src)
      0: csr_new_pc_req = 1;
      1: exe_new_pc_req = 1;
      default: wfi_req = 1;
    endcase
    tick(1);
    clear_in();
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    pc = 32'h0;
    clear_in();
    #1 rst = 1;
    tick(3);
    rst = 0;
    tick(1);
    check("rst_req", {31'd0, req[0]}, 32'd0);
    check("rst_code", {28'd0, code[0]}, 32'd14);
    check("rst_tval", tval[0], 32'd0);
    check("rst_cnt", {24'd0, cnt[0]}, 32'd0);

    // Misaligned PC under IALIGN=32; legal under IALIGN=16.
    pc = 32'h1002; fetch_valid = 1;
    tick(1);
    check("t1_req", {31'd0, req[0]}, 32'd1);
    check("t1_code", {28'd0, code[0]}, 32'd0);
    check("t1_tval", tval[0], 32'h1002);
    check("t1_cnt", {24'd0, cnt[0]}, 32'd1);
    check("t1_ialign16_req", {31'd0, req[1]}, 32'd0);
    fetch_valid = 0;
    tick(1);
    flush_cycle(1);
    check("t1_flushed", {31'd0, req[0]}, 32'd0);

    // Page fault held across a stalled ack, consumed by an unstalled ack.
    pc = 32'h2000; i_page_fault = 1; fetch_valid = 1;
    tick(1);
    clear_in(); if_stall = 1; exc_ack_i = 1;
    tick(3);
    check("t2_hold_req", {31'd0, req[0]}, 32'd1);
    check("t2_hold_code", {28'd0, code[0]}, 32'd12);
    check("t2_hold_tval", tval[0], 32'h2000);
    check("t2_hold_cnt", {24'd0, cnt[0]}, 32'd2);
    if_stall = 0;
    tick(1);
    check("t2_acked_req", {31'd0, req[0]}, 32'd0);
    check("t2_acked_code", {28'd0, code[0]}, 32'd14);
    exc_ack_i = 0; pc = 32'h2004; i_page_fault = 1; fetch_valid = 1;
    tick(2);
    check("t2_ignored_req", {31'd0, req[0]}, 32'd0);
    check("t2_ignored_cnt", {24'd0, cnt[0]}, 32'd2);
    csr_new_pc_req = 1;
    tick(1);
    check("t2_flush_beats_fault", {31'd0, req[0]}, 32'd0);
    clear_in();
    tick(1);

    // Misaligned + page fault: page fault wins.
    pc = 32'h1001; i_page_fault = 1; fetch_valid = 1;
    tick(1);
    check("t3_code", {28'd0, code[0]}, 32'd12);
    check("t3_tval", tval[0], 32'h1001);
    flush_cycle(2);
    // Odd PC is misaligned under both alignments.
    pc = 32'h1001; fetch_valid = 1;
    tick(1);
    check("t3b_code", {28'd0, code[0]}, 32'd0);
    check("t3b_code16", {28'd0, code[1]}, 32'd0);
    check("t3b_cnt", {24'd0, cnt[0]}, 32'd4);
    flush_cycle(0);

    // Fault together with a redirect: dropped, counter unchanged.
    pc = 32'h4000; i_page_fault = 1; fetch_valid = 1; exe_new_pc_req = 1;
    tick(1);
    check("t4_req", {31'd0, req[0]}, 32'd0);
    check("t4_cnt", {24'd0, cnt[0]}, 32'd4);
    exe_new_pc_req = 0;
    tick(1);
    check("t4_pend", {31'd0, req[0]}, 32'd1);
    flush_cycle(1);
    check("t4_flush_pend", {31'd0, req[0]}, 32'd0);

    // Access fault: only raised when the feature is built in.
    pc = 32'h3000; i_access_fault = 1; fetch_valid = 1;
    tick(1);
`ifdef FETCH_ACCESS_FAULT_EN
    check("t6_req", {31'd0, req[0]}, 32'd1);
    check("t6_code", {28'd0, code[0]}, 32'd1);
    check("t6_tval", tval[0], 32'h3000);
`else
    check("t6_req", {31'd0, req[0]}, 32'd0);
    check("t6_code", {28'd0, code[0]}, 32'd14);
`endif
    flush_cycle(0);

    // Counter saturation on the CNT_W=2 instance.
    for (int k = 0; k < 5; k++) begin
      pc = 32'h5000 + 32'(k * 4); i_page_fault = 1; fetch_valid = 1;
      tick(1);
      flush_cycle(k % 3);
    end
    check("t5_cnt_sat", {24'd0, cnt[2]}, 32'd3);

    // Asynchronous reset in the middle of a pending exception.
    pc = 32'h6000; i_page_fault = 1; fetch_valid = 1;
    tick(1);
    check("t5_pend_before_rst", {31'd0, req[0]}, 32'd1);
    clear_in();
    #2 rst = 1;
    #1;
    check("t5_arst_req", {31'd0, req[0]}, 32'd0);
    check("t5_arst_code", {28'd0, code[0]}, 32'd14);
    check("t5_arst_tval", tval[0], 32'd0);
    check("t5_arst_cnt", {24'd0, cnt[0]}, 32'd0);
    check("t5_arst_cnt2", {24'd0, cnt[2]}, 32'd0);
    tick(1);
    rst = 0;
    tick(2);
    pc = 32'h7002; fetch_valid = 1;
    tick(1);
    check("t5_after_rst_cnt", {24'd0, cnt[0]}, 32'd1);
    check("t5_after_rst_code", {28'd0, code[0]}, 32'd0);
    clear_in();
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
